// File: rtl/bsg_round_robin_dispatch.sv
// rtl/bsg_round_robin_dispatch.sv - one-entry buffered round-robin splitter of one stream onto els_p consumers
// The buffered item goes to the first ready consumer at or after ptr_q; busy consumers are skipped.
module bsg_round_robin_dispatch #(
  parameter int els_p    = 64,
  parameter int width_p  = 32,
  localparam int tag_w_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                v_i,
  input  logic [width_p-1:0]  data_i,
  output logic                ready_o,
  input  logic [els_p-1:0]    ready_i,
  output logic [els_p-1:0]    v_o,
  output logic [width_p-1:0]  data_o,
  output logic [tag_w_lp-1:0] tag_o,
  output logic [31:0]         count_o
);

  localparam logic [tag_w_lp:0] els_lp = (tag_w_lp + 1)'(els_p);

  logic                full_q, full_d;
  logic [width_p-1:0]  data_q, data_d;
  logic [tag_w_lp-1:0] ptr_q, ptr_d;
  logic [31:0]         count_q, count_d;

  logic [2*els_p-1:0]  ready_dbl;
  logic [els_p-1:0]    ready_rot;
  logic                found;
  logic [tag_w_lp:0]   off;
  logic [tag_w_lp:0]   sum;
  logic [tag_w_lp-1:0] sel;
  logic                any_ready;
  logic                disp;
  logic                accept;

  always_comb begin
    // Rotate readiness so index 0 of ready_rot is the port at ptr_q.
    ready_dbl = {ready_i, ready_i} >> ptr_q;
    ready_rot = ready_dbl[els_p-1:0];
    found = 1'b0;
    off   = '0;
    for (int j = 0; j < els_p; j++) begin
      if (!found && ready_rot[j]) begin
        found = 1'b1;
        off   = (tag_w_lp + 1)'(j);
      end
    end
    sum = {1'b0, ptr_q} + off;
    if (sum >= els_lp) sum = sum - els_lp;
    sel = sum[tag_w_lp-1:0];

    any_ready = |ready_i;
    disp      = full_q & any_ready;
    ready_o   = reset_n_i & (~full_q | disp);
    accept    = v_i & ready_o;

    v_o = '0;
    if (disp) v_o[sel] = 1'b1;
    tag_o   = disp ? sel : '0;
    data_o  = data_q;
    count_o = count_q;

    full_d  = full_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    if (accept) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (disp) begin
      full_d = 1'b0;
    end
    if (disp) begin
      ptr_d   = ({1'b0, sel} == els_lp - 1'b1) ? '0 : sel + 1'b1;
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      full_q  <= 1'b0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      full_q  <= full_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Payload is qualified by full_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

endmodule
